// File: rtl/pwm_pkg.sv
// Shared constants, register map, CTRL bit positions and FSM encoding for the PWM fader.
package pwm_pkg;

    localparam int unsigned MAX_DUTY = 100;
    localparam int unsigned DUTY_W   = 7;
    localparam int unsigned STEP_W   = 16;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned DATA_W   = 32;

    localparam logic [ADDR_W-1:0] ADDR_TARGET = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(2);

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_ABORT = 1;
    localparam int unsigned CTRL_JUMP  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_JUMP = 2'd2
    } state_e;

    // Read-back word for the CTRL/STATUS address.
    typedef struct packed {
        logic [22:0]       rsvd_hi;
        logic              busy;
        logic              rsvd_lo;
        logic [DUTY_W-1:0] cur;
    } status_t;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] v,
                                                     input logic [DUTY_W-1:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Reloadable down-counter; expire marks the last cycle of a step period.
module pwm_step_timer
    import pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [STEP_W-1:0] value,
    output logic              expire
);

    logic [STEP_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - STEP_W'(1);
        end
    end

    // A load of N lands the owner's action exactly N edges after the load edge.
    assign expire = (count == STEP_W'(1));

endmodule

// File: rtl/pwm_fader.sv
// Register-programmed duty-cycle fader: ramps or jumps the PWM duty toward a target.
module pwm_fader #(
    parameter int unsigned DEFAULT_STEP = 500,
    parameter int unsigned MAX_DUTY     = pwm_pkg::MAX_DUTY
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [pwm_pkg::ADDR_W-1:0]   A,
    input  logic [pwm_pkg::DATA_W-1:0]   WD,
    input  logic                         WE,
    output logic [pwm_pkg::DATA_W-1:0]   RD,
    output logic [pwm_pkg::DUTY_W-1:0]   PWM_WD,
    output logic                         PWM_WE,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned DUTY_W = pwm_pkg::DUTY_W;
    localparam int unsigned STEP_W = pwm_pkg::STEP_W;
    localparam int unsigned DATA_W = pwm_pkg::DATA_W;
    localparam logic [DUTY_W-1:0] DUTY_LIMIT = DUTY_W'(MAX_DUTY);
    localparam logic [STEP_W-1:0] STEP_RESET = STEP_W'(DEFAULT_STEP);

    pwm_pkg::state_e  state_q, state_nxt;
    pwm_pkg::status_t status;

    logic [DUTY_W-1:0] cur_q, cur_nxt, target_q;
    logic [STEP_W-1:0] step_q, step_eff;
    logic              pwm_we_nxt, done_nxt, timer_load, expire;
    logic              ctrl_wr, start_req, abort_req, jump_req;
    logic              unused_wd;

    assign unused_wd = ^WD[DATA_W-1:STEP_W];

    assign ctrl_wr   = WE && (A == pwm_pkg::ADDR_CTRL);
    assign start_req = ctrl_wr && WD[pwm_pkg::CTRL_START];
    assign abort_req = ctrl_wr && WD[pwm_pkg::CTRL_ABORT];
    assign jump_req  = ctrl_wr && WD[pwm_pkg::CTRL_JUMP];

    // A programmed step of zero still advances one duty unit per cycle.
    assign step_eff = (step_q == '0) ? STEP_W'(1) : step_q;

    // Software-visible configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
            step_q   <= STEP_RESET;
        end else if (WE) begin
            if (A == pwm_pkg::ADDR_TARGET) begin
                target_q <= pwm_pkg::clamp_duty(WD[DUTY_W-1:0], DUTY_LIMIT);
            end
            if (A == pwm_pkg::ADDR_STEP) begin
                step_q <= WD[STEP_W-1:0];
            end
        end
    end

    pwm_step_timer u_step_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .value  (step_eff),
        .expire (expire)
    );

    // Next-state and output decode.
    always_comb begin
        state_nxt  = state_q;
        cur_nxt    = cur_q;
        pwm_we_nxt = 1'b0;
        done_nxt   = 1'b0;
        timer_load = 1'b0;
        case (state_q)
            pwm_pkg::ST_IDLE: begin
                if (!abort_req) begin
                    if (jump_req) begin
                        state_nxt = pwm_pkg::ST_JUMP;
                    end else if (start_req) begin
                        if (cur_q == target_q) begin
                            done_nxt = 1'b1;
                        end else begin
                            timer_load = 1'b1;
                            state_nxt  = pwm_pkg::ST_RAMP;
                        end
                    end
                end
            end
            pwm_pkg::ST_RAMP: begin
                if (abort_req) begin
                    state_nxt = pwm_pkg::ST_IDLE;
                end else if (expire) begin
                    timer_load = 1'b1;
                    // Direction is taken from the live target at every step.
                    if (cur_q == target_q) begin
                        done_nxt  = 1'b1;
                        state_nxt = pwm_pkg::ST_IDLE;
                    end else begin
                        cur_nxt    = (cur_q < target_q) ? cur_q + DUTY_W'(1) : cur_q - DUTY_W'(1);
                        pwm_we_nxt = 1'b1;
                        if (cur_nxt == target_q) begin
                            done_nxt  = 1'b1;
                            state_nxt = pwm_pkg::ST_IDLE;
                        end
                    end
                end
            end
            pwm_pkg::ST_JUMP: begin
                state_nxt = pwm_pkg::ST_IDLE;
                if (!abort_req) begin
                    cur_nxt    = target_q;
                    pwm_we_nxt = 1'b1;
                    done_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = pwm_pkg::ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= pwm_pkg::ST_IDLE;
            cur_q   <= '0;
            PWM_WE  <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cur_q   <= cur_nxt;
            PWM_WE  <= pwm_we_nxt;
            done    <= done_nxt;
            busy    <= (state_nxt != pwm_pkg::ST_IDLE);
        end
    end

    assign PWM_WD = cur_q;

    // Bus read mux.
    always_comb begin
        status      = '0;
        status.busy = busy;
        status.cur  = cur_q;
        RD          = '0;
        case (A)
            pwm_pkg::ADDR_TARGET: RD = DATA_W'(target_q);
            pwm_pkg::ADDR_STEP:   RD = DATA_W'(step_q);
            pwm_pkg::ADDR_CTRL:   RD = status;
            default:              RD = '0;
        endcase
    end

endmodule

// File: tb/tb_pwm_fader.sv
// Self-checking bench for pwm_fader: directed scenarios plus randomized traffic against a timestamp model.
module tb_pwm_fader;

    localparam int unsigned DEF_STEP = 500;
    localparam int unsigned MAXD     = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic [6:0]  PWM_WD;
    logic        PWM_WE;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    pwm_fader #(.DEFAULT_STEP(DEF_STEP), .MAX_DUTY(MAXD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .WD     (WD),
        .WE     (WE),
        .RD     (RD),
        .PWM_WD (PWM_WD),
        .PWM_WE (PWM_WE),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 ramping, 2 jumping; ramps scheduled by absolute cycle stamps.
    int m_cur, m_target, m_step, m_mode, m_cyc, m_next;
    bit m_we, m_done;

    function automatic int eff_step(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_target = 0; m_step = DEF_STEP; m_mode = 0;
        m_next = 0; m_we = 0; m_done = 0;
    endtask

    task automatic model_edge();
        bit ctrl, st, ab, jp;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_cyc++;
        m_we = 0;
        m_done = 0;
        ctrl = WE && (A == 2'd2);
        ab = ctrl && WD[1];
        jp = ctrl && WD[2] && !ab;
        st = ctrl && WD[0] && !ab && !jp;
        case (m_mode)
            0: begin
                if (jp) m_mode = 2;
                else if (st) begin
                    if (m_cur == m_target) m_done = 1;
                    else begin
                        m_mode = 1;
                        m_next = m_cyc + eff_step(m_step);
                    end
                end
            end
            1: begin
                if (ab) m_mode = 0;
                else if (m_cyc == m_next) begin
                    if (m_cur == m_target) begin
                        m_done = 1;
                        m_mode = 0;
                    end else begin
                        m_cur = m_cur + ((m_target > m_cur) ? 1 : -1);
                        m_we = 1;
                        if (m_cur == m_target) begin
                            m_done = 1;
                            m_mode = 0;
                        end else m_next = m_cyc + eff_step(m_step);
                    end
                end
            end
            default: begin
                m_mode = 0;
                if (!ab) begin
                    m_cur = m_target;
                    m_we = 1;
                    m_done = 1;
                end
            end
        endcase
        if (WE && A == 2'd0) m_target = (int'(WD[6:0]) > int'(MAXD)) ? int'(MAXD) : int'(WD[6:0]);
        if (WE && A == 2'd1) m_step = int'(WD[15:0]);
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_target);
            2'd1:    return 32'(m_step);
            2'd2:    return {23'b0, (m_mode != 0), 1'b0, 7'(m_cur)};
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        A = a; WD = d; WE = 1'b1;
        tick();
        WE = 1'b0; WD = 32'd0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        A = a;
        #1;
        d = RD;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; A = 2'd0; WD = 32'd0; WE = 1'b0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] r;
        do_reset();
        bus_write(2'd1, 32'd9);
        bus_write(2'd0, 32'd40);
        bus_write(2'd2, 32'd1);
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (PWM_WE !== 1'b0) begin errors++; $display("FAIL reset_pwm_we: got %b expected 0", PWM_WE); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (PWM_WD !== 7'd0) begin errors++; $display("FAIL reset_pwm_wd: got %0d expected 0", PWM_WD); end
        read_reg(2'd0, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_rd_target: got %0d expected 0", r); end
        read_reg(2'd1, r);
        checks++; if (r !== 32'(DEF_STEP)) begin errors++; $display("FAIL reset_rd_step: got %0d expected %0d", r, DEF_STEP); end
        read_reg(2'd2, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_rd_status: got %0h expected 0", r); end
        read_reg(2'd3, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_rd_reserved: got %0h expected 0", r); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ramp_up();
        bit exp_we, exp_done;
        do_reset();
        bus_write(2'd1, 32'd4);
        bus_write(2'd0, 32'd3);
        bus_write(2'd2, 32'd1);
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_we = (k % 4 == 0) && (k <= 12);
            exp_done = (k == 12);
            checks++; if (PWM_WE !== exp_we) begin errors++; $display("FAIL ramp_up_we k=%0d: got %b expected %b", k, PWM_WE, exp_we); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL ramp_up_done k=%0d: got %b expected %b", k, done, exp_done); end
            if (exp_we) begin
                checks++; if (PWM_WD !== 7'(k / 4)) begin errors++; $display("FAIL ramp_up_wd k=%0d: got %0d expected %0d", k, PWM_WD, k / 4); end
            end
            if (k < 12) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ramp_up_busy k=%0d: got %b expected 1", k, busy); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_up_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_ramp_down();
        bit exp_we, exp_done;
        bus_write(2'd0, 32'd1);
        bus_write(2'd1, 32'd2);
        bus_write(2'd2, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_we = (k == 2) || (k == 4);
            exp_done = (k == 4);
            checks++; if (PWM_WE !== exp_we) begin errors++; $display("FAIL ramp_down_we k=%0d: got %b expected %b", k, PWM_WE, exp_we); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL ramp_down_done k=%0d: got %b expected %b", k, done, exp_done); end
            if (exp_we) begin
                checks++; if (PWM_WD !== 7'(3 - k / 2)) begin errors++; $display("FAIL ramp_down_wd k=%0d: got %0d expected %0d", k, PWM_WD, 3 - k / 2); end
            end
            if (k != 4) begin
                checks++; if (busy !== (k < 4)) begin errors++; $display("FAIL ramp_down_busy k=%0d: got %b expected %b", k, busy, (k < 4)); end
            end
        end
    endtask

    task automatic test_clamp_jump();
        logic [31:0] r;
        bit hit;
        bus_write(2'd0, 32'd120);
        read_reg(2'd0, r);
        checks++; if (r !== 32'd100) begin errors++; $display("FAIL clamp_target: got %0d expected 100", r); end
        bus_write(2'd2, 32'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL jump_busy: got %b expected 1", busy); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            hit = (k == 1);
            checks++; if (PWM_WE !== hit) begin errors++; $display("FAIL jump_we k=%0d: got %b expected %b", k, PWM_WE, hit); end
            checks++; if (done !== hit) begin errors++; $display("FAIL jump_done k=%0d: got %b expected %b", k, done, hit); end
        end
        checks++; if (PWM_WD !== 7'd100) begin errors++; $display("FAIL jump_wd: got %0d expected 100", PWM_WD); end
        read_reg(2'd2, r);
        checks++; if (r !== 32'd100) begin errors++; $display("FAIL jump_status: got %0h expected 64", r); end
        // abort has priority and is ignored while idle, so a 7 write does nothing
        bus_write(2'd2, 32'd7);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (PWM_WE !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL prio_abort k=%0d: got we %b done %b expected 0 0", k, PWM_WE, done); end
        end
        // jump beats start even with cur already at target
        bus_write(2'd2, 32'd5);
        for (int k = 1; k <= 3; k++) begin
            tick();
            hit = (k == 1);
            checks++; if (PWM_WE !== hit || done !== hit) begin errors++; $display("FAIL prio_jump k=%0d: got we %b done %b expected %b %b", k, PWM_WE, done, hit, hit); end
        end
    endtask

    task automatic test_abort();
        bit found;
        int strobes, dones;
        logic [31:0] r;
        do_reset();
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'd50);
        bus_write(2'd2, 32'd1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (PWM_WE === 1'b1 && PWM_WD === 7'd5) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_reach5: got no strobe with duty 5 expected one within 200 cycles"); end
        bus_write(2'd2, 32'd2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        strobes = 0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (PWM_WE === 1'b1) strobes++;
            if (done === 1'b1) dones++;
        end
        checks++; if (strobes != 0) begin errors++; $display("FAIL abort_strobes: got %0d expected 0", strobes); end
        checks++; if (dones != 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", dones); end
        checks++; if (PWM_WD !== 7'd5) begin errors++; $display("FAIL abort_cur: got %0d expected 5", PWM_WD); end
        read_reg(2'd2, r);
        checks++; if (r !== 32'd5) begin errors++; $display("FAIL abort_status: got %0h expected 5", r); end
    endtask

    task automatic test_retarget_equal();
        bit found;
        do_reset();
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'd10);
        bus_write(2'd2, 32'd1);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (PWM_WE === 1'b1 && PWM_WD === 7'd2) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL retarget_reach2: got no strobe with duty 2 expected one within 50 cycles"); end
        bus_write(2'd0, 32'd2);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (PWM_WE !== 1'b0) begin errors++; $display("FAIL retarget_we k=%0d: got %b expected 0", k, PWM_WE); end
            checks++; if (done !== (k == 2)) begin errors++; $display("FAIL retarget_done k=%0d: got %b expected %b", k, done, (k == 2)); end
        end
        checks++; if (busy !== 1'b0 || PWM_WD !== 7'd2) begin errors++; $display("FAIL retarget_end: got busy %b duty %0d expected 0 2", busy, PWM_WD); end
    endtask

    task automatic test_zero_step_reset();
        logic [31:0] r;
        int strobes;
        do_reset();
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'd2);
        bus_write(2'd2, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (PWM_WE !== (k <= 2)) begin errors++; $display("FAIL zero_step_we k=%0d: got %b expected %b", k, PWM_WE, (k <= 2)); end
            checks++; if (done !== (k == 2)) begin errors++; $display("FAIL zero_step_done k=%0d: got %b expected %b", k, done, (k == 2)); end
            if (k <= 2) begin
                checks++; if (PWM_WD !== 7'(k)) begin errors++; $display("FAIL zero_step_wd k=%0d: got %0d expected %0d", k, PWM_WD, k); end
            end
        end
        read_reg(2'd1, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL zero_step_rd: got %0d expected 0", r); end
        bus_write(2'd0, 32'd50);
        bus_write(2'd2, 32'd1);
        repeat (3) tick();
        checks++; if (PWM_WD !== 7'd5 || busy !== 1'b1) begin errors++; $display("FAIL midramp: got duty %0d busy %b expected 5 1", PWM_WD, busy); end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (PWM_WD !== 7'd0 || PWM_WE !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midramp_reset: got duty %0d we %b busy %b expected 0 0 0", PWM_WD, PWM_WE, busy); end
        read_reg(2'd1, r);
        checks++; if (r !== 32'(DEF_STEP)) begin errors++; $display("FAIL midramp_step: got %0d expected %0d", r, DEF_STEP); end
        rst_n = 1'b1;
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (PWM_WE === 1'b1) strobes++;
        end
        checks++; if (strobes != 0 || PWM_WD !== 7'd0) begin errors++; $display("FAIL post_reset: got %0d strobes duty %0d expected 0 0", strobes, PWM_WD); end
    endtask

    task automatic test_random();
        logic [1:0]  a;
        logic [31:0] d, exp_rd;
        int r;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 5) == 0) begin
                if (a == 2'd1) d = {d[31:16], 16'($urandom_range(0, 5))};
                else if (a == 2'd2) begin
                    r = $urandom_range(0, 9);
                    d = (r < 6) ? 32'd1 : (r < 8) ? 32'd4 : (r == 8) ? 32'd2 : 32'($urandom_range(0, 7));
                end
                WE = 1'b1;
            end else begin
                WE = 1'b0;
            end
            A = a;
            WD = d;
            #1;
            exp_rd = model_rd(a);
            checks++; if (RD !== exp_rd) begin errors++; $display("FAIL rand_rd n=%0d A=%0d: got %0h expected %0h", n, a, RD, exp_rd); end
            tick();
            checks++; if (PWM_WE !== m_we) begin errors++; $display("FAIL rand_we n=%0d: got %b expected %b", n, PWM_WE, m_we); end
            checks++; if (done !== m_done) begin errors++; $display("FAIL rand_done n=%0d: got %b expected %b", n, done, m_done); end
            checks++; if (busy !== (m_mode != 0)) begin errors++; $display("FAIL rand_busy n=%0d: got %b expected %b", n, busy, (m_mode != 0)); end
            checks++; if (PWM_WD !== 7'(m_cur)) begin errors++; $display("FAIL rand_duty n=%0d: got %0d expected %0d", n, PWM_WD, m_cur); end
        end
        WE = 1'b0;
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_clamp_jump();
        test_abort();
        test_retarget_equal();
        test_zero_step_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 The block SHALL have parameter DEFAULT_STEP, default 500, meaning the reset value of the step-period register in clk cycles.
REQ-002 The block SHALL have parameter MAX_DUTY, default 100, meaning the highest legal duty value in percent.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 A  input  2  register select: 0 = TARGET, 1 = STEP, 2 = CTRL/STATUS, 3 = reserved.
REQ-006 WD  input  32  bus write data.
REQ-007 WE  input  1  bus write strobe, single cycle.
REQ-008 RD  output  32  bus read data, combinational from A.
REQ-009 PWM_WD  output  7  duty value presented to the PWM peripheral.
REQ-010 PWM_WE  output  1  one-cycle write strobe to the PWM peripheral.
REQ-011 busy  output  1  high while a ramp is in progress.
REQ-012 done  output  1  one-cycle pulse when a ramp or jump completes.

Function
REQ-013 A write to TARGET SHALL store WD[6:0], clamped to MAX_DUTY when the value exceeds it.
REQ-014 A write to STEP SHALL store WD[15:0]; a stored value of 0 SHALL behave as 1.
REQ-015 A write to CTRL SHALL decode the bits as follows: bit0 = start, bit1 = abort, bit2 = jump; priority is abort > jump > start.
REQ-016 The FSM SHALL have exactly three states: IDLE, RAMP and JUMP.
REQ-017 In IDLE, start SHALL do one of two things: if cur == target, pulse done on the next cycle with no PWM_WE; otherwise load the step timer with STEP and enter RAMP.
REQ-018 In RAMP, the timer SHALL decrement once per cycle; when it expires, cur SHALL move 1 toward target, PWM_WE=1 with PWM_WD=new cur for exactly one cycle, and the timer SHALL reload from the current STEP.
REQ-019 The first PWM_WE after start SHALL occur exactly STEP cycles after the start-write edge; subsequent strobes SHALL occur every STEP cycles.
REQ-020 When the new cur equals target, the FSM SHALL pulse done in the same cycle as the final PWM_WE and enter IDLE.
REQ-021 The step direction SHALL be re-evaluated at every step, so a TARGET write during RAMP takes effect at the next step.
REQ-022 A target written equal to cur during RAMP SHALL end the ramp at the next step expiry with done=1 and no PWM_WE.
REQ-023 A STEP write during RAMP SHALL take effect at the next reload only.
REQ-024 Abort SHALL enter IDLE on the next cycle, leave cur unchanged and issue no done.
REQ-025 Start or jump received while in RAMP SHALL be ignored; abort received while in IDLE SHALL be ignored.
REQ-026 Jump SHALL enter JUMP, set cur=target, and assert PWM_WE with done for one cycle; it SHALL then return to IDLE, and this holds even when cur == target.
REQ-027 busy SHALL equal 1 in RAMP and JUMP.
REQ-028 RD SHALL return: A=0 {25'b0, target}; A=1 {16'b0, STEP}; A=2 {23'b0, busy, 1'b0, cur}; A=3 0.
REQ-029 PWM_WD SHALL always equal cur; cur SHALL never leave the range 0..MAX_DUTY.

Reset
REQ-030 On rst_n low, the block SHALL immediately (asynchronously) set: state=IDLE, cur=0, target=0, STEP=DEFAULT_STEP, timer=0, PWM_WE=0, done=0, busy=0.
REQ-031 Reset asserted mid-ramp SHALL abandon the ramp with no further PWM_WE strobe.

Structure
REQ-032 The shared package pwm_pkg SHALL hold MAX_DUTY, the register addresses, the CTRL bit positions and the FSM state encoding.
REQ-033 The reloadable down-counter SHALL be a sub-module named pwm_step_timer, with inputs load/value and output expire.

Verification
REQ-034 Scenario 1: STEP=4, TARGET=3, start -> PWM_WE at start+4, +8 and +12 with PWM_WD 1, 2, 3; done coincides with the third strobe.
REQ-035 Scenario 2: cur=3, TARGET=1, STEP=2, start -> PWM_WD 2 then 1, two cycles apart; busy falls after done.
REQ-036 Scenario 3: TARGET=120 written -> RD(A=0)=100; jump -> PWM_WD=100, one PWM_WE, done.
REQ-037 Scenario 4: ramp from 0 to 50 with abort after cur=5 -> no further PWM_WE, cur stays 5, no done.
REQ-038 Scenario 5: STEP=0, TARGET=2, start -> strobes on consecutive steps one cycle apart; rst_n pulsed mid-ramp -> cur=0 and STEP=500 read back.
